imem_dmem_arbiter: RTL and testbench
====================================

# imem_dmem_arbiter

Two-requester arbiter that shares the single unified memory port of the MCU between the instruction-fetch path and the load/store unit. It sits between the core's fetch and LSU request interfaces and the memory/bus slave. It serialises one transaction at a time and routes the response back to the granted requester. It suppresses fetch responses invalidated by a pipeline redirect.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, consecutive LSU grants allowed while fetch waits (range 1..15)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_req_i  in  1  fetch read request; held until if_ack_o or kill_i
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  fetch response valid, one cycle
- if_rdata_o  out  DATA_W  fetch read data
- kill_i  in  1  fetch redirect; abandons outstanding fetch
- ls_req_i  in  1  LSU request; held until ls_ack_o
- ls_we_i  in  1  1 = store
- ls_be_i  in  DATA_W/8  byte enables
- ls_addr_i  in  ADDR_W  LSU address
- ls_wdata_i  in  DATA_W  store data
- ls_ack_o  out  1  LSU response valid, one cycle
- ls_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  write enable
- mem_be_o  out  DATA_W/8  byte enables (all ones for fetch)
- mem_addr_o  out  ADDR_W  address
- mem_wdata_o  out  DATA_W  write data (zero for fetch)
- mem_ack_i  in  1  memory completion, one cycle
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_LS, DRAIN.
- IDLE: if ls_req_i and the LSU is not blocked by starvation → capture LSU request into output registers, go to BUSY_LS. Else if if_req_i and not kill_i → capture fetch, go to BUSY_IF. Else stay.
- BUSY_x: mem_req_o=1 with registered fields. On mem_ack_i, pulse the matching ack combinationally (mem_ack_i gated), pass mem_rdata_i, return to IDLE.
- kill_i in BUSY_IF: the memory transaction cannot be aborted. Go to DRAIN; mem_req_o stays high until mem_ack_i. if_ack_o is suppressed and the state returns to IDLE.
- kill_i and mem_ack_i in the same BUSY_IF cycle: if_ack_o=0, next state IDLE.
- kill_i in IDLE/BUSY_LS/DRAIN: no effect beyond blocking a new fetch grant that cycle.
- if_rdata_o/ls_rdata_o = mem_rdata_i when their ack is high, else 0.
- Starvation counter (4 bits): increments on each LSU grant while if_req_i=1. It clears on any fetch grant, or in any cycle with if_req_i=0. When counter == STARVE_MAX, the fetch wins the next IDLE arbitration.

## Timing
- Reset values: mem_req_o, mem_we_o, if_ack_o, ls_ack_o = 0. mem_addr_o, mem_wdata_o, mem_be_o = 0. State = IDLE, counter = 0.
- Request sampled in IDLE in cycle N → mem_req_o high in cycle N+1.
- Memory ack in cycle M → requester ack in cycle M (0 added latency); the next grant is decided in cycle M+1.
- Minimum transaction spacing is 2 cycles (grant + ack), so back-to-back throughput is 1 transaction per 2 cycles with a zero-wait memory.
- mem_* outputs are stable for the entire BUSY/DRAIN period.
- rst_n low mid-transaction: forced to IDLE next edge with no ack issued. The slave must also be reset.

## Configuration
- IMEM_ARB_STARVE_GUARD_EN defined: starvation counter and STARVE_MAX override are active as described.
- Undefined: strict LSU priority. No counter is instantiated and STARVE_MAX is ignored, so fetch is granted only in IDLE cycles with ls_req_i=0.

## Test plan
- Fetch only: if_req_i=1, addr 0x100, memory acks 2 cycles after mem_req_o → mem_addr_o=0x100, mem_be_o=0xF, if_ack_o one pulse with rdata 0xDEADBEEF.
- Simultaneous requests: if_req_i and ls_req_i (store, addr 0x2000, be 0x3) in the same cycle → LSU granted first (mem_we_o=1, be=0x3), fetch granted in the IDLE cycle after ls_ack_o.
- Starvation (macro on, STARVE_MAX=4): ls_req_i held continuously with if_req_i → exactly 4 LSU grants, then a fetch grant, then the LSU resumes. With the macro off, the fetch is never granted.
- Kill during fetch: kill_i asserted 1 cycle after the fetch grant, memory acks 3 cycles later → mem_req_o held until ack, if_ack_o stays 0, and a subsequent LSU request is granted the cycle after.
- Kill coincident with mem_ack_i in BUSY_IF → no if_ack_o, state IDLE next cycle.
- Reset asserted in BUSY_LS before ack → next cycle all outputs 0, state IDLE, no ls_ack_o.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction at a time.
// Define IMEM_ARB_STARVE_GUARD_EN to bound how long fetch can be starved by LSU traffic.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                kill_i,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_ack_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DRAIN} state_e;

  state_e state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                grantLs, grantIf, lsBlocked;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadStarveMax
    $error("imem_dmem_arbiter: STARVE_MAX must be in 1..15");
  end

`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  logic [3:0] starveCnt_q, starveCnt_d;

  // Only hold the LSU off when the waiting fetch can actually take the slot.
  assign lsBlocked = (starveCnt_q == StarveMax) && if_req_i && !kill_i;

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!if_req_i || grantIf) begin
      starveCnt_d = 4'd0;
    end else if (grantLs) begin
      starveCnt_d = starveCnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starveCnt_q <= 4'd0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  assign lsBlocked = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grantLs     = 1'b0;
    grantIf     = 1'b0;
    if_ack_o    = 1'b0;
    ls_ack_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ls_req_i && !lsBlocked) begin
          grantLs     = 1'b1;
          state_d     = BUSY_LS;
          mem_we_d    = ls_we_i;
          mem_be_d    = ls_be_i;
          mem_addr_d  = ls_addr_i;
          mem_wdata_d = ls_wdata_i;
        end else if (if_req_i && !kill_i) begin
          grantIf     = 1'b1;
          state_d     = BUSY_IF;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
        end
      end
      BUSY_IF: begin
        // An in-flight fetch cannot be aborted; a redirect only hides its response.
        if (mem_ack_i) begin
          if_ack_o = !kill_i;
          state_d  = IDLE;
        end else if (kill_i) begin
          state_d = DRAIN;
        end
      end
      BUSY_LS: begin
        if (mem_ack_i) begin
          ls_ack_o = 1'b1;
          state_d  = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req_o   = (state_q != IDLE);
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_ack_o ? mem_rdata_i : '0;
  assign ls_rdata_o  = ls_ack_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed self-checking bench for imem_dmem_arbiter; starvation expectations follow
// IMEM_ARB_STARVE_GUARD_EN, the same macro the design uses.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        kill_i;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_ack_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .kill_i(kill_i),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_ack_o(ls_ack_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %0h expected 0", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we: got %0h expected 0", mem_we_o); end
    checks++; if (mem_be_o !== 4'h0) begin errors++; $display("[TB] FAIL rst_mem_be: got %0h expected 0", mem_be_o); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %0h expected 0", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_wdata: got %0h expected 0", mem_wdata_o); end
    checks++; if (if_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_if_ack: got %0h expected 0", if_ack_o); end
    checks++; if (ls_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ls_ack: got %0h expected 0", ls_ack_o); end
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_only();
    cycle();
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    settle();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL fo_idle_req: got %0h expected 0", mem_req_o); end
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fo_req: got %0h expected 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL fo_addr: got %0h expected 100", mem_addr_o); end
    checks++; if (mem_be_o !== 4'hF) begin errors++; $display("[TB] FAIL fo_be: got %0h expected f", mem_be_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL fo_we: got %0h expected 0", mem_we_o); end
    checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL fo_wdata: got %0h expected 0", mem_wdata_o); end
    checks++; if (if_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL fo_early_ack: got %0h expected 0", if_ack_o); end
    cycle();
    settle();
    checks++; if (if_ack_o !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL fo_wait: got ack %0h req %0h expected ack 0 req 1", if_ack_o, mem_req_o); end
    cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    settle();
    checks++; if (if_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL fo_ack: got %0h expected 1", if_ack_o); end
    checks++; if (if_rdata_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fo_rdata: got %0h expected deadbeef", if_rdata_o); end
    checks++; if (ls_ack_o !== 1'b0 || ls_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL fo_ls_quiet: got ack %0h rdata %0h expected 0 0", ls_ack_o, ls_rdata_o); end
    cycle();
    mem_ack_i = 1'b0;
    if_req_i  = 1'b0;
    settle();
    checks++; if (if_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL fo_done: got ack %0h req %0h expected 0 0", if_ack_o, mem_req_o); end
  endtask

  task automatic test_simultaneous();
    cycle();
    if_req_i   = 1'b1;
    if_addr_i  = 32'h104;
    ls_req_i   = 1'b1;
    ls_we_i    = 1'b1;
    ls_be_i    = 4'h3;
    ls_addr_i  = 32'h2000;
    ls_wdata_i = 32'hCAFE0001;
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin errors++; $display("[TB] FAIL sim_ls_first: got req %0h we %0h expected 1 1", mem_req_o, mem_we_o); end
    checks++; if (mem_be_o !== 4'h3) begin errors++; $display("[TB] FAIL sim_ls_be: got %0h expected 3", mem_be_o); end
    checks++; if (mem_addr_o !== 32'h2000) begin errors++; $display("[TB] FAIL sim_ls_addr: got %0h expected 2000", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'hCAFE0001) begin errors++; $display("[TB] FAIL sim_ls_wdata: got %0h expected cafe0001", mem_wdata_o); end
    cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h11111111;
    settle();
    checks++; if (ls_ack_o !== 1'b1 || if_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL sim_ls_ack: got ls %0h if %0h expected 1 0", ls_ack_o, if_ack_o); end
    checks++; if (ls_rdata_o !== 32'h11111111) begin errors++; $display("[TB] FAIL sim_ls_rdata: got %0h expected 11111111", ls_rdata_o); end
    cycle();
    mem_ack_i = 1'b0;
    ls_req_i  = 1'b0;
    ls_we_i   = 1'b0;
    settle();
    checks++; if (mem_req_o !== 1'b0 || ls_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL sim_gap: got req %0h ls_ack %0h expected 0 0", mem_req_o, ls_ack_o); end
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104) begin errors++; $display("[TB] FAIL sim_if_grant: got req %0h addr %0h expected 1 104", mem_req_o, mem_addr_o); end
    checks++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL sim_if_fields: got we %0h be %0h wdata %0h expected 0 f 0", mem_we_o, mem_be_o, mem_wdata_o); end
    cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h12345678;
    settle();
    checks++; if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h12345678) begin errors++; $display("[TB] FAIL sim_if_ack: got ack %0h rdata %0h expected 1 12345678", if_ack_o, if_rdata_o); end
    cycle();
    mem_ack_i = 1'b0;
    if_req_i  = 1'b0;
    cycle();
  endtask

  task automatic test_kill_during_fetch();
    cycle();
    if_req_i  = 1'b1;
    if_addr_i = 32'h200;
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL kill_grant: got req %0h addr %0h expected 1 200", mem_req_o, mem_addr_o); end
    cycle();
    kill_i   = 1'b1;
    if_req_i = 1'b0;
    settle();
    checks++; if (if_ack_o !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL kill_cycle: got ack %0h req %0h expected 0 1", if_ack_o, mem_req_o); end
    cycle();
    kill_i = 1'b0;
    settle();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin errors++; $display("[TB] FAIL kill_drain_hold: got req %0h addr %0h expected 1 200", mem_req_o, mem_addr_o); end
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b1 || if_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL kill_drain_wait: got req %0h ack %0h expected 1 0", mem_req_o, if_ack_o); end
    cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0BAD0;
    ls_req_i    = 1'b1;
    ls_we_i     = 1'b0;
    ls_be_i     = 4'hF;
    ls_addr_i   = 32'h300;
    ls_wdata_i  = 32'h0;
    settle();
    checks++; if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL kill_suppress: got ack %0h rdata %0h expected 0 0", if_ack_o, if_rdata_o); end
    checks++; if (ls_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL kill_no_ls_ack: got %0h expected 0", ls_ack_o); end
    cycle();
    mem_ack_i = 1'b0;
    settle();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL kill_idle: got %0h expected 0", mem_req_o); end
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300 || mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL kill_ls_grant: got req %0h addr %0h we %0h expected 1 300 0", mem_req_o, mem_addr_o, mem_we_o); end
    cycle();
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h0A0B0C0D;
    settle();
    checks++; if (ls_ack_o !== 1'b1 || ls_rdata_o !== 32'h0A0B0C0D) begin errors++; $display("[TB] FAIL kill_ls_ack: got ack %0h rdata %0h expected 1 a0b0c0d", ls_ack_o, ls_rdata_o); end
    cycle();
    mem_ack_i = 1'b0;
    ls_req_i  = 1'b0;
    cycle();
  endtask

  task automatic test_kill_with_ack();
    cycle();
    if_req_i  = 1'b1;
    if_addr_i = 32'h400;
    cycle();
    kill_i      = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h55AA55AA;
    settle();
    checks++; if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL kack_suppress: got ack %0h rdata %0h expected 0 0", if_ack_o, if_rdata_o); end
    cycle();
    kill_i    = 1'b0;
    mem_ack_i = 1'b0;
    if_req_i  = 1'b0;
    settle();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL kack_idle: got %0h expected 0", mem_req_o); end
    cycle();
  endtask

  task automatic test_starvation();
    logic [7:0] seen [0:7];
    logic [7:0] want [0:5];
    int n = 0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
    want = '{8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h46, 8'h4C};
`else
    want = '{8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C};
`endif
    for (int i = 0; i < 8; i++) seen[i] = 8'h00;
    cycle();
    ls_req_i  = 1'b1;
    ls_we_i   = 1'b0;
    ls_be_i   = 4'hF;
    ls_addr_i = 32'h600;
    if_req_i  = 1'b1;
    if_addr_i = 32'h700;
    mem_ack_i = 1'b0;
    // Zero-wait memory: acknowledge in every cycle the request is up.
    for (int c = 0; c < 12; c++) begin
      cycle();
      mem_ack_i   = mem_req_o;
      mem_rdata_i = 32'(c);
      settle();
      if (n < 8 && ls_ack_o === 1'b1) begin seen[n] = 8'h4C; n++; end
      if (n < 8 && if_ack_o === 1'b1) begin seen[n] = 8'h46; n++; end
    end
    checks++; if (n !== 6) begin errors++; $display("[TB] FAIL starve_count: got %0d acks expected 6", n); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (seen[k] !== want[k]) begin errors++; $display("[TB] FAIL starve_order[%0d]: got %c expected %c", k, seen[k], want[k]); end
    end
    cycle();
    ls_req_i  = 1'b0;
    if_req_i  = 1'b0;
    mem_ack_i = mem_req_o;
    cycle();
    mem_ack_i = 1'b0;
    settle();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL starve_end_idle: got %0h expected 0", mem_req_o); end
  endtask

  task automatic test_reset_mid_ls();
    cycle();
    ls_req_i   = 1'b1;
    ls_we_i    = 1'b1;
    ls_be_i    = 4'hC;
    ls_addr_i  = 32'h500;
    ls_wdata_i = 32'h77;
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h500) begin errors++; $display("[TB] FAIL rmid_grant: got req %0h addr %0h expected 1 500", mem_req_o, mem_addr_o); end
    cycle();
    rst_n = 1'b0;
    settle();
    checks++; if (ls_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_no_ack_pre: got %0h expected 0", ls_ack_o); end
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_req_we: got req %0h we %0h expected 0 0", mem_req_o, mem_we_o); end
    checks++; if (mem_be_o !== 4'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0) begin errors++; $display("[TB] FAIL rmid_fields: got be %0h addr %0h wdata %0h expected 0 0 0", mem_be_o, mem_addr_o, mem_wdata_o); end
    checks++; if (ls_ack_o !== 1'b0 || if_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_acks: got ls %0h if %0h expected 0 0", ls_ack_o, if_ack_o); end
    cycle();
    rst_n    = 1'b1;
    ls_req_i = 1'b0;
    ls_we_i  = 1'b0;
    cycle();
    settle();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_after: got %0h expected 0", mem_req_o); end
  endtask

  initial begin
    rst_n       = 1'b0;
    if_req_i    = 1'b0;
    if_addr_i   = 32'h0;
    kill_i      = 1'b0;
    ls_req_i    = 1'b0;
    ls_we_i     = 1'b0;
    ls_be_i     = 4'h0;
    ls_addr_i   = 32'h0;
    ls_wdata_i  = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_kill_during_fetch();
    test_kill_with_ack();
    test_starvation();
    test_reset_mid_ls();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
